// File: rtl/ecc_apb_cmd_master.sv
// Command sequencer: programs the ECC register bank over APB, waits for operation_done, returns the result.
// Optional watchdog in WAIT_DONE enabled by defining ECC_TIMEOUT_EN.
// state     | meaning
// IDLE      | ready for a command
// SETUP     | APB setup phase of current register write
// ACCESS    | APB access phase of current register write
// WAIT_DONE | all writes issued, waiting for operation_done
// RESP      | result presented until rsp_ready
module ecc_apb_cmd_master #(
    parameter int unsigned                  AMBA_WORD       = 32,
    parameter int unsigned                  AMBA_ADDR_WIDTH = 20,
    parameter int unsigned                  DATA_WIDTH      = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0]   ADDR_CTRL       = 'h00,
    parameter logic [AMBA_ADDR_WIDTH-1:0]   ADDR_DATA_IN    = 'h04,
    parameter logic [AMBA_ADDR_WIDTH-1:0]   ADDR_CW_WIDTH   = 'h08,
    parameter logic [AMBA_ADDR_WIDTH-1:0]   ADDR_NOISE      = 'h0C,
    parameter int unsigned                  TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_mode,
    input  logic [1:0]                 cmd_cw_width,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

    state_t                state;
    logic [1:0]            idx;
    logic [1:0]            mode_q;
    logic [1:0]            cw_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] noise_q;

    logic                       last_wr;
    logic [1:0]                 nxt_idx;
    logic [AMBA_ADDR_WIDTH-1:0] nxt_addr;
    logic [AMBA_WORD-1:0]       nxt_wdata;
    logic                       timeout_hit;

    // Write slots: 0 CW_WIDTH, 1 NOISE (full mode only), 2 DATA_IN, 3 CTRL
    always_comb begin
        last_wr   = (idx == 2'd3);
        nxt_idx   = idx + 2'd1;
        if (idx == 2'd0 && mode_q != 2'b10)
            nxt_idx = 2'd2;
        nxt_addr  = ADDR_CTRL;
        nxt_wdata = AMBA_WORD'(mode_q);
        case (nxt_idx)
            2'd1: begin
                nxt_addr  = ADDR_NOISE;
                nxt_wdata = AMBA_WORD'(noise_q);
            end
            2'd2: begin
                nxt_addr  = ADDR_DATA_IN;
                nxt_wdata = AMBA_WORD'(data_q);
            end
            default: begin
                nxt_addr  = ADDR_CTRL;
                nxt_wdata = AMBA_WORD'(mode_q);
            end
        endcase
    end

`ifdef ECC_TIMEOUT_EN
    // rsp_valid rises TIMEOUT_CYCLES cycles after the CTRL access cycle
    localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES >= 2) ? 16'(TIMEOUT_CYCLES - 2) : 16'd0;

    logic [15:0] wait_cnt;
    logic        timeout_q;

    assign timeout_hit = (state == WAIT_DONE) && (wait_cnt >= TO_LAST);
    assign rsp_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state == ACCESS && last_wr) begin
            wait_cnt  <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt  <= wait_cnt + 16'd1;
            timeout_q <= !operation_done && timeout_hit;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            mode_q     <= '0;
            cw_q       <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            cmd_ready  <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_errors <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= cmd_mode;
                        cw_q      <= cmd_cw_width;
                        data_q    <= cmd_data;
                        noise_q   <= cmd_noise;
                        idx       <= 2'd0;
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b1;
                        PADDR     <= ADDR_CW_WIDTH;
                        PWDATA    <= AMBA_WORD'(cmd_cw_width);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    PENABLE <= 1'b0;
                    if (last_wr) begin
                        PSEL   <= 1'b0;
                        PWRITE <= 1'b0;
                        PADDR  <= '0;
                        PWDATA <= '0;
                        state  <= WAIT_DONE;
                    end else begin
                        idx    <= nxt_idx;
                        PADDR  <= nxt_addr;
                        PWDATA <= nxt_wdata;
                        state  <= SETUP;
                    end
                end
                WAIT_DONE: begin
                    if (operation_done) begin
                        rsp_data   <= data_out;
                        rsp_errors <= (mode_q == 2'b00) ? 2'b00 : num_of_errors;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (timeout_hit) begin
                        rsp_data   <= '0;
                        rsp_errors <= 2'b00;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
// Directed, table-driven bench for ecc_apb_cmd_master (default build, watchdog disabled).
module tb_ecc_apb_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [1:0]  cmd_cw_width;
    logic [31:0] cmd_data;
    logic [31:0] cmd_noise;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout;

    int n_cmp = 0;
    int n_err = 0;

    ecc_apb_cmd_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_cw_width(cmd_cw_width), .cmd_data(cmd_data), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  cw;
        logic [31:0] data;
        logic [31:0] noise;
        logic [31:0] dout;
        logic [1:0]  nerr;
        int          dly;
        int          hold;
        bit          early;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [19:0] ea[4];
        logic [31:0] ed[4];
        int n;
        ea[0] = 20'h08; ed[0] = {30'd0, v.cw}; n = 1;
        if (v.mode == 2'b10) begin
            ea[n] = 20'h0C; ed[n] = v.noise; n++;
        end
        ea[n] = 20'h04; ed[n] = v.data; n++;
        ea[n] = 20'h00; ed[n] = {30'd0, v.mode}; n++;

        @(negedge clk);
        chk("idle_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_mode = v.mode; cmd_cw_width = v.cw;
        cmd_data = v.data; cmd_noise = v.noise;
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            if (w == 0) begin
                cmd_valid = 1'b0;
                cmd_data = 32'h0; cmd_noise = 32'h0; cmd_mode = 2'b11; cmd_cw_width = 2'b00;
            end
            chk("apb_setup", {9'd0, cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {9'd0, 5'b00101, ea[w], ed[w]});
            @(negedge clk);
            chk("apb_access", {9'd0, cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {9'd0, 5'b00111, ea[w], ed[w]});
            if (w == n - 1 && v.early) begin
                operation_done = 1'b1; data_out = 32'hFFFF_FFFF; num_of_errors = 2'b11;
            end
        end
        for (int d = 0; d <= v.dly; d++) begin
            @(negedge clk);
            operation_done = 1'b0;
            chk("wait_idle", {61'd0, PSEL, rsp_valid, cmd_ready}, 64'd0);
            if (d == v.dly) begin
                operation_done = 1'b1; data_out = v.dout; num_of_errors = v.nerr;
            end
        end
        @(negedge clk);
        operation_done = 1'b0; data_out = 32'h5555_AAAA; num_of_errors = 2'b11;
        chk("rsp", {27'd0, rsp_valid, cmd_ready, rsp_data, rsp_errors, rsp_timeout},
            {27'd0, 1'b1, 1'b0, v.exp_data, v.exp_err, 1'b0});
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("rsp_hold", {28'd0, rsp_valid, cmd_ready, PSEL, rsp_data, rsp_errors},
                {28'd0, 3'b100, v.exp_data, v.exp_err});
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_cw_width = 2'b01; cmd_data = 32'h1; cmd_noise = 32'h1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("after_hs", {61'd0, rsp_valid, cmd_ready, PSEL}, {61'd0, 3'b010});
    endtask

    initial begin
        vecs[0] = '{mode: 2'b00, cw: 2'd2, data: 32'h0000_00A5, noise: 32'h0000_FFFF,
                    dout: 32'h0000_1234, nerr: 2'b11, dly: 0, hold: 0, early: 1'b0,
                    exp_data: 32'h0000_1234, exp_err: 2'b00};
        vecs[1] = '{mode: 2'b10, cw: 2'd1, data: 32'h0000_005A, noise: 32'h0000_0001,
                    dout: 32'h0000_CAFE, nerr: 2'b01, dly: 2, hold: 1, early: 1'b0,
                    exp_data: 32'h0000_CAFE, exp_err: 2'b01};
        vecs[2] = '{mode: 2'b01, cw: 2'd3, data: 32'hDEAD_BEEF, noise: 32'h0000_0000,
                    dout: 32'h0BAD_F00D, nerr: 2'b10, dly: 1, hold: 5, early: 1'b0,
                    exp_data: 32'h0BAD_F00D, exp_err: 2'b10};
        vecs[3] = '{mode: 2'b10, cw: 2'd0, data: 32'h0000_003C, noise: 32'h8000_0000,
                    dout: 32'h0000_7777, nerr: 2'b10, dly: 2, hold: 0, early: 1'b1,
                    exp_data: 32'h0000_7777, exp_err: 2'b10};
        vecs[4] = '{mode: 2'b00, cw: 2'd1, data: 32'h1234_5678, noise: 32'h0F0F_0F0F,
                    dout: 32'h8765_4321, nerr: 2'b10, dly: 2, hold: 2, early: 1'b1,
                    exp_data: 32'h8765_4321, exp_err: 2'b00};

        rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_cw_width = 2'b00;
        cmd_data = 32'h0; cmd_noise = 32'h0; operation_done = 1'b0;
        data_out = 32'h0; num_of_errors = 2'b00; rsp_ready = 1'b0;
        #23;
        chk("reset_ctl", {7'd0, cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
            {7'd0, 5'b10000, 20'h0, 32'h0});
        chk("reset_rsp", {29'd0, rsp_data, rsp_errors, rsp_timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // Reset asserted in the SETUP of the DATA_IN write of a mode-01 command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_cw_width = 2'd2;
        cmd_data = 32'h0000_0099; cmd_noise = 32'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_setup", {42'd0, PSEL, PENABLE, PADDR}, {42'd0, 2'b10, 20'h04});
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {61'd0, PSEL, PENABLE, cmd_ready}, {61'd0, 3'b001});
        @(negedge clk);
        operation_done = 1'b1; data_out = 32'hABCD; num_of_errors = 2'b01;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            operation_done = 1'b0;
            chk("post_rst", {61'd0, cmd_ready, rsp_valid, PSEL}, {61'd0, 3'b100});
        end

        run_vec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
